// File: rtl/instruction_fetch_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_if
// Bundles the bus signals of the fetch stage: the instruction-memory
// request/acknowledge read port, the redirect input and the downstream
// valid/ready instruction port. Signal names keep the original port names.
//   master : the fetch stage (drives oIMEM_*, oVALID, oIR, oPC, oMISALIGN)
//   slave  : memory / downstream / redirect source side
// ---------------------------------------------------------------------------
interface instruction_fetch_if #(
    parameter int unsigned PC_W = 8
);
    logic            oIMEM_REQ;
    logic [PC_W-1:0] oIMEM_ADDR;
    logic            iIMEM_ACK;
    logic [31:0]     iIMEM_DATA;
    logic            iREDIRECT;
    logic [PC_W-1:0] iREDIRECT_PC;
    logic            iREADY;
    logic            oVALID;
    logic [31:0]     oIR;
    logic [PC_W-1:0] oPC;
    logic            oMISALIGN;

    modport master (
        output oIMEM_REQ, oIMEM_ADDR, oVALID, oIR, oPC, oMISALIGN,
        input  iIMEM_ACK, iIMEM_DATA, iREDIRECT, iREDIRECT_PC, iREADY
    );

    modport slave (
        input  oIMEM_REQ, oIMEM_ADDR, oVALID, oIR, oPC, oMISALIGN,
        output iIMEM_ACK, iIMEM_DATA, iREDIRECT, iREDIRECT_PC, iREADY
    );
endinterface

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
// Fetch stage: owns the program counter, reads instruction memory through a
// request/acknowledge port and hands each word (with its PC) downstream via
// valid/ready. A redirect flushes the held word and discards any in-flight
// read; a misaligned redirect target parks the stage in an error state.
// Ports:
//   iCLK   : clock, rising edge
//   iRST_N : asynchronous active-low reset
//   bus    : instruction_fetch_if.master (memory port, redirect, downstream)
// ---------------------------------------------------------------------------
module instruction_fetch #(
    parameter int unsigned     PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [31:0]     NOP      = 32'h00000013
) (
    input  logic                   iCLK,
    input  logic                   iRST_N,
    instruction_fetch_if.master    bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD,
        S_DROP,
        S_ERR
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_pend_pc;
    logic            r_pend_err;
    logic            r_req;
    logic            r_valid;
    logic [31:0]     r_ir;
    logic [PC_W-1:0] r_opc;
    logic            r_mis;

    logic [PC_W-1:0] w_pc_nxt;
    logic [PC_W-1:0] w_pend_pc_nxt;
    logic            w_pend_err_nxt;
    logic            w_req_nxt;
    logic            w_valid_nxt;
    logic [31:0]     w_ir_nxt;
    logic [PC_W-1:0] w_opc_nxt;
    logic            w_mis_nxt;

    logic            w_ack;
    logic            w_busy;
    logic            w_tgt_ok;

    // An ack only counts while a request is actually on the bus.
    assign w_ack    = bus.iIMEM_ACK & r_req;
    // Request still outstanding after this cycle: a redirect must drain it.
    assign w_busy   = r_req & ~bus.iIMEM_ACK;
    assign w_tgt_ok = (bus.iREDIRECT_PC[1:0] == 2'b00);

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_pend_pc_nxt  = r_pend_pc;
        w_pend_err_nxt = r_pend_err;
        w_valid_nxt    = r_valid;
        w_ir_nxt       = r_ir;
        w_opc_nxt      = r_opc;
        w_mis_nxt      = r_mis;

        if (bus.iREDIRECT) begin
            w_valid_nxt = 1'b0;
            w_ir_nxt    = NOP;
            // Covers FETCH and DROP alike: if the read completes in the same
            // cycle there is nothing left to drain, so the redirect acts at
            // once; otherwise the read is drained in DROP first.
            if (w_tgt_ok) begin
                w_mis_nxt = 1'b0;
                if (w_busy) begin
                    w_state_nxt    = S_DROP;
                    w_pend_pc_nxt  = bus.iREDIRECT_PC;
                    w_pend_err_nxt = 1'b0;
                end else begin
                    w_state_nxt = S_FETCH;
                    w_pc_nxt    = bus.iREDIRECT_PC;
                end
            end else begin
                w_mis_nxt = 1'b1;
                if (w_busy) begin
                    w_state_nxt    = S_DROP;
                    w_pend_err_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_ERR;
                end
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_FETCH;
                end
                S_FETCH: begin
                    if (w_ack) begin
                        w_ir_nxt    = bus.iIMEM_DATA;
                        w_opc_nxt   = r_pc;
                        w_valid_nxt = 1'b1;
                        w_pc_nxt    = r_pc + PC_W'(4);
                        w_state_nxt = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (bus.iREADY) begin
                        w_valid_nxt = 1'b0;
                        w_ir_nxt    = NOP;
                        w_state_nxt = S_FETCH;
                    end
                end
                S_DROP: begin
                    if (w_ack) begin
                        if (r_pend_err) begin
                            w_state_nxt = S_ERR;
                        end else begin
                            w_pc_nxt    = r_pend_pc;
                            w_state_nxt = S_FETCH;
                        end
                    end
                end
                S_ERR: begin
                    w_state_nxt = S_ERR;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end

        w_req_nxt = (w_state_nxt == S_FETCH) || (w_state_nxt == S_DROP);
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_pc       <= RESET_PC;
            r_pend_pc  <= '0;
            r_pend_err <= 1'b0;
            r_req      <= 1'b0;
            r_valid    <= 1'b0;
            r_ir       <= NOP;
            r_opc      <= '0;
            r_mis      <= 1'b0;
        end else begin
            r_pc       <= w_pc_nxt;
            r_pend_pc  <= w_pend_pc_nxt;
            r_pend_err <= w_pend_err_nxt;
            r_req      <= w_req_nxt;
            r_valid    <= w_valid_nxt;
            r_ir       <= w_ir_nxt;
            r_opc      <= w_opc_nxt;
            r_mis      <= w_mis_nxt;
        end
    end

    assign bus.oIMEM_REQ  = r_req;
    assign bus.oIMEM_ADDR = r_pc;
    assign bus.oVALID     = r_valid;
    assign bus.oIR        = r_ir;
    assign bus.oPC        = r_opc;
    assign bus.oMISALIGN  = r_mis;

endmodule

// File: tb/tb_instruction_fetch.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch
// Drives the fetch stage with directed scenarios followed by randomized
// memory latency, redirects, backpressure and resets, and compares every
// output each cycle against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h00000013;

    logic clk;
    logic rst_n;

    instruction_fetch_if #(.PC_W(8)) bus ();

    instruction_fetch #(
        .PC_W     (8),
        .RESET_PC (8'h00),
        .NOP      (NOP)
    ) dut (
        .iCLK   (clk),
        .iRST_N (rst_n),
        .bus    (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec;
    int unsigned n_err;

    // Reference model: one outstanding read (address + whether its data is
    // still wanted), the word held for downstream, the next fetch address.
    logic        m_req;
    logic [7:0]  m_addr;
    logic        m_keep;
    logic [7:0]  m_pc;
    logic        m_halt;
    logic        m_valid;
    logic [31:0] m_ir;
    logic [7:0]  m_opc;
    logic        m_mis;

    int unsigned wcnt;
    logic        spurious;
    logic [31:0] salt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_req   = 1'b0;
        m_addr  = 8'h00;
        m_keep  = 1'b0;
        m_pc    = 8'h00;
        m_halt  = 1'b0;
        m_valid = 1'b0;
        m_ir    = NOP;
        m_opc   = 8'h00;
        m_mis   = 1'b0;
        wcnt    = 0;
    endtask

    task automatic model_update(input logic ack, input logic [31:0] data, input logic rd,
                                input logic [7:0] rpc, input logic rdy);
        logic done;
        done = m_req && ack;
        if (done) m_req = 1'b0;
        if (rd) begin
            m_valid = 1'b0;
            m_ir    = NOP;
            if (rpc[1:0] == 2'b00) begin
                m_mis  = 1'b0;
                m_halt = 1'b0;
                m_pc   = rpc;
            end else begin
                m_mis  = 1'b1;
                m_halt = 1'b1;
            end
            if (m_req) m_keep = 1'b0;
        end else if (done && m_keep) begin
            m_valid = 1'b1;
            m_ir    = data;
            m_opc   = m_addr;
            m_pc    = m_addr + 8'd4;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
            m_ir    = NOP;
        end
        if (!m_req && !m_halt && !m_valid) begin
            m_req  = 1'b1;
            m_addr = m_pc;
            m_keep = 1'b1;
        end
    endtask

    task automatic compare_all();
        check("req", {31'b0, bus.oIMEM_REQ}, {31'b0, m_req});
        if (m_req) check("addr", {24'b0, bus.oIMEM_ADDR}, {24'b0, m_addr});
        check("valid", {31'b0, bus.oVALID}, {31'b0, m_valid});
        check("ir", bus.oIR, m_ir);
        check("opc", {24'b0, bus.oPC}, {24'b0, m_opc});
        check("misalign", {31'b0, bus.oMISALIGN}, {31'b0, m_mis});
    endtask

    // One clock: apply inputs after a falling edge, advance the model,
    // then compare at the next falling edge.
    task automatic step(input logic ack, input logic [31:0] data, input logic rd,
                        input logic [7:0] rpc, input logic rdy);
        bus.iIMEM_ACK    = ack;
        bus.iIMEM_DATA   = data;
        bus.iREDIRECT    = rd;
        bus.iREDIRECT_PC = rpc;
        bus.iREADY       = rdy;
        model_update(ack, data, rd, rpc, rdy);
        @(negedge clk);
        compare_all();
    endtask

    // Memory responder: acks once the current request has waited lat cycles.
    task automatic auto_step(input int unsigned lat, input logic rd, input logic [7:0] rpc,
                             input logic rdy);
        logic        ack;
        logic [31:0] data;
        ack  = 1'b0;
        data = {m_addr, m_addr, m_addr, m_addr} ^ salt;
        if (m_req) begin
            if (wcnt >= lat) begin
                ack  = 1'b1;
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end else begin
            ack = spurious && ($urandom_range(0, 3) == 0);
        end
        step(ack, data, rd, rpc, rdy);
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_req", {31'b0, bus.oIMEM_REQ}, 32'd0);
        check("rst_valid", {31'b0, bus.oVALID}, 32'd0);
        check("rst_ir", bus.oIR, NOP);
        check("rst_opc", {24'b0, bus.oPC}, 32'd0);
        check("rst_mis", {31'b0, bus.oMISALIGN}, 32'd0);
        model_reset();
        bus.iIMEM_ACK = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        compare_all();
        // Late ack right after release must be ignored.
        step(1'b1, 32'hDEADBEEF, 1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  rpc;
        logic [31:0] r;
        n_vec    = 0;
        n_err    = 0;
        spurious = 1'b0;
        salt     = 32'h0;
        rst_n    = 1'b0;
        bus.iIMEM_ACK    = 1'b0;
        bus.iIMEM_DATA   = 32'h0;
        bus.iREDIRECT    = 1'b0;
        bus.iREDIRECT_PC = 8'h00;
        bus.iREADY       = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        compare_all();

        // First fetch after reset.
        step(1'b0, 32'h0, 1'b0, 8'h00, 1'b0);
        check("first_req", {31'b0, bus.oIMEM_REQ}, 32'd1);
        check("first_addr", {24'b0, bus.oIMEM_ADDR}, 32'h00);
        step(1'b1, 32'h00100093, 1'b0, 8'h00, 1'b0);
        check("first_valid", {31'b0, bus.oVALID}, 32'd1);
        check("first_ir", bus.oIR, 32'h00100093);
        check("first_opc", {24'b0, bus.oPC}, 32'h00);
        step(1'b0, 32'h0, 1'b0, 8'h00, 1'b1);

        // Streaming with zero-wait memory, then backpressure at oPC=08.
        for (int i = 0; i < 20 && !(m_valid && m_opc == 8'h08); i++) auto_step(0, 1'b0, 8'h00, 1'b1);
        check("reach_08", {31'b0, bus.oVALID}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            auto_step(0, 1'b0, 8'h00, 1'b0);
            check("stall_valid", {31'b0, bus.oVALID}, 32'd1);
            check("stall_opc", {24'b0, bus.oPC}, 32'h08);
            check("stall_noreq", {31'b0, bus.oIMEM_REQ}, 32'd0);
        end
        auto_step(0, 1'b0, 8'h00, 1'b1);

        // PC wraps from FC to 00.
        auto_step(0, 1'b1, 8'hFC, 1'b0);
        for (int i = 0; i < 10 && !(m_valid && m_opc == 8'hFC); i++) auto_step(0, 1'b0, 8'h00, 1'b0);
        auto_step(0, 1'b0, 8'h00, 1'b1);
        check("wrap_addr", {24'b0, bus.oIMEM_ADDR}, 32'h00);

        // Redirect while holding the word at oPC=10.
        auto_step(0, 1'b1, 8'h10, 1'b0);
        for (int i = 0; i < 10 && !(m_valid && m_opc == 8'h10); i++) auto_step(0, 1'b0, 8'h00, 1'b0);
        check("hold_10", {24'b0, bus.oPC}, 32'h10);
        auto_step(0, 1'b1, 8'h40, 1'b1);
        check("redir_flush", {31'b0, bus.oVALID}, 32'd0);
        check("redir_addr", {24'b0, bus.oIMEM_ADDR}, 32'h40);
        auto_step(0, 1'b0, 8'h00, 1'b0);
        check("redir_opc", {24'b0, bus.oPC}, 32'h40);

        // Slow memory: redirect while the read to 20 is in flight.
        auto_step(3, 1'b1, 8'h20, 1'b0);
        check("slow_addr", {24'b0, bus.oIMEM_ADDR}, 32'h20);
        auto_step(3, 1'b1, 8'h80, 1'b0);
        for (int i = 0; i < 2; i++) begin
            auto_step(3, 1'b0, 8'h00, 1'b1);
            check("drop_addr", {24'b0, bus.oIMEM_ADDR}, 32'h20);
        end
        auto_step(3, 1'b0, 8'h00, 1'b1);
        check("drop_valid", {31'b0, bus.oVALID}, 32'd0);
        check("after_drop", {24'b0, bus.oIMEM_ADDR}, 32'h80);

        // Misaligned redirect parks the stage; aligned redirect recovers.
        auto_step(0, 1'b1, 8'h42, 1'b0);
        check("mis_set", {31'b0, bus.oMISALIGN}, 32'd1);
        for (int i = 0; i < 2; i++) begin
            auto_step(0, 1'b0, 8'h00, 1'b1);
            check("err_noreq", {31'b0, bus.oIMEM_REQ}, 32'd0);
        end
        auto_step(0, 1'b1, 8'h44, 1'b0);
        check("mis_clr", {31'b0, bus.oMISALIGN}, 32'd0);
        check("recover_addr", {24'b0, bus.oIMEM_ADDR}, 32'h44);

        // Asynchronous reset with a request pending, then with a word held.
        async_reset();
        for (int i = 0; i < 10 && !m_valid; i++) auto_step(1, 1'b0, 8'h00, 1'b0);
        check("valid_before_rst", {31'b0, bus.oVALID}, 32'd1);
        async_reset();

        // Randomized traffic.
        spurious = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            salt = $urandom;
            r    = $urandom;
            rpc  = r[7:0];
            if ($urandom_range(0, 4) != 0) rpc[1:0] = 2'b00;
            if ($urandom_range(0, 499) == 0) async_reset();
            else auto_step($urandom_range(0, 3), ($urandom_range(0, 9) == 0), rpc,
                           ($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
